// File: rtl/led_pkg.sv
// Shared types and defaults for the HUB75 level-bar scan driver.
package led_pkg;

  localparam int DEF_COLS      = 32;
  localparam int DEF_ROW_PAIRS = 16;
  localparam int DEF_ON_CYCLES = 256;

  typedef enum logic [1:0] {SHIFT, BLANK, LATCH, SHOW} state_t;

  // Bit order {r, g, b}
  typedef logic [2:0] rgb_t;
  localparam rgb_t OFF    = 3'b000;
  localparam rgb_t GREEN  = 3'b010;
  localparam rgb_t YELLOW = 3'b110;
  localparam rgb_t RED    = 3'b100;

  localparam logic [4:0] THR_YELLOW = 5'd16;
  localparam logic [4:0] THR_RED    = 5'd24;

endpackage

// File: rtl/bar_pixel.sv
// Colour of one bar pixel from the captured level and the physical row y (0 = top).
module bar_pixel
  import led_pkg::*;
(
  input  logic [5:0] level,
  input  logic [4:0] y,
  output rgb_t       rgb
);

  logic [5:0] h;
  logic [4:0] l;

  always_comb begin
    h = (level > 6'd32) ? 6'd32 : level;
    l = 5'd31 - y;
    if ({1'b0, l} >= h)     rgb = OFF;
    else if (l < THR_YELLOW) rgb = GREEN;
    else if (l < THR_RED)    rgb = YELLOW;
    else                     rgb = RED;
  end

endmodule

// File: rtl/hub75_bar_driver.sv
// HUB75 1/16-scan driver: renders the captured screen level as a full-width vertical bar.
module hub75_bar_driver
  import led_pkg::*;
#(
  parameter int COLS      = DEF_COLS,
  parameter int ROW_PAIRS = DEF_ROW_PAIRS,
  parameter int ON_CYCLES = DEF_ON_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] screen,
  output logic       r1,
  output logic       g1,
  output logic       b1,
  output logic       r2,
  output logic       g2,
  output logic       b2,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       LAT,
  output logic       OEN,
  output logic       OCLK
);

  localparam int CNT_MAX = (2*COLS > ON_CYCLES) ? 2*COLS : ON_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = $clog2(ROW_PAIRS);

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [RW-1:0] r, r_d;
  logic [5:0]    level, level_d, lvl_eff;
  logic [3:0]    abcd_q, abcd_d;
  rgb_t          up_q, lo_q, up_d, lo_d, up_pix, lo_pix;
  logic          lat_q, oen_q, oclk_q, lat_d, oen_d, oclk_d;
  logic          capture;
  logic [4:0]    y_up, y_lo;

  assign y_up = 5'(r);
  assign y_lo = 5'(r) + 5'(ROW_PAIRS);

  // First shift cycle of row 0 uses the incoming screen directly so column 0 sees the new frame level.
  assign capture = (state == SHIFT) && (cnt == '0) && (r == '0);
  assign lvl_eff = capture ? screen : level;

  bar_pixel u_pix_up (.level(lvl_eff), .y(y_up), .rgb(up_pix));
  bar_pixel u_pix_lo (.level(lvl_eff), .y(y_lo), .rgb(lo_pix));

  always_comb begin
    state_d = state;
    cnt_d   = cnt + CW'(1);
    r_d     = r;
    level_d = lvl_eff;
    abcd_d  = abcd_q;
    up_d    = OFF;
    lo_d    = OFF;
    lat_d   = 1'b0;
    oen_d   = 1'b1;
    oclk_d  = 1'b0;
    case (state)
      SHIFT: begin
        up_d   = up_pix;
        lo_d   = lo_pix;
        oclk_d = cnt[0];
        if (cnt == CW'(2*COLS - 1)) begin
          state_d = BLANK;
          cnt_d   = '0;
        end
      end
      BLANK: begin
        state_d = LATCH;
        cnt_d   = '0;
      end
      LATCH: begin
        lat_d   = 1'b1;
        abcd_d  = 4'(r);
        state_d = SHOW;
        cnt_d   = '0;
      end
      SHOW: begin
        oen_d = 1'b0;
        if (cnt == CW'(ON_CYCLES - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
          r_d     = (r == RW'(ROW_PAIRS - 1)) ? '0 : r + RW'(1);
        end
      end
      default: begin
        state_d = SHIFT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= SHIFT;
      cnt    <= '0;
      r      <= '0;
      level  <= '0;
      abcd_q <= '0;
      up_q   <= OFF;
      lo_q   <= OFF;
      lat_q  <= 1'b0;
      oen_q  <= 1'b1;
      oclk_q <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      r      <= r_d;
      level  <= level_d;
      abcd_q <= abcd_d;
      up_q   <= up_d;
      lo_q   <= lo_d;
      lat_q  <= lat_d;
      oen_q  <= oen_d;
      oclk_q <= oclk_d;
    end
  end

  assign {r1, g1, b1} = up_q;
  assign {r2, g2, b2} = lo_q;
  assign {D, C, B, A} = abcd_q;
  assign LAT  = lat_q;
  assign OEN  = oen_q;
  assign OCLK = oclk_q;

endmodule

// File: tb/tb_hub75_bar_driver.sv
// Bench for hub75_bar_driver: per-cycle behavioural model compare plus directed literal checks.
module tb_hub75_bar_driver;

  localparam int COLS  = 32;
  localparam int RP    = 16;
  localparam int ON    = 256;
  localparam int ROWP  = 2*COLS + 2 + ON;
  localparam int FRAME = ROWP * RP;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] screen = 6'd0;
  logic r1, g1, b1, r2, g2, b2, A, B, C, D, LAT, OEN, OCLK;

  int tests = 0;
  int fails = 0;

  hub75_bar_driver #(.COLS(COLS), .ROW_PAIRS(RP), .ON_CYCLES(ON)) dut (
    .clk(clk), .reset(reset), .screen(screen),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .A(A), .B(B), .C(C), .D(D), .LAT(LAT), .OEN(OEN), .OCLK(OCLK)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] pix(input int lvl, input int y);
    int h, l;
    h = (lvl > 32) ? 32 : lvl;
    l = 31 - y;
    if (l >= h) return 3'b000;
    if (l < 16) return 3'b010;
    if (l < 24) return 3'b110;
    return 3'b100;
  endfunction

  // {LAT, OEN, OCLK, D, C, B, A, r1, g1, b1, r2, g2, b2}
  function automatic logic [12:0] exp_vec(input int n, input int lvl);
    int q, pos, r, abcd;
    logic [2:0] up, lo;
    logic lat, oen, oclk;
    if (n < 0) return 13'b0_1_0_0000_000_000;
    q = n / ROWP; pos = n % ROWP; r = q % RP;
    abcd = (pos >= 2*COLS + 1) ? r : ((q == 0) ? 0 : (q - 1) % RP);
    up = 3'b000; lo = 3'b000; lat = 1'b0; oen = 1'b1; oclk = 1'b0;
    if (pos < 2*COLS) begin
      oclk = 1'(pos % 2);
      up = pix(lvl, r);
      lo = pix(lvl, r + RP);
    end else if (pos == 2*COLS + 1) lat = 1'b1;
    else if (pos > 2*COLS + 1) oen = 1'b0;
    return {lat, oen, oclk, 4'(abcd), up, lo};
  endfunction

  // Output-cycle index since the last reset edge (-1 = reset values showing)
  int n_out = -1;
  int m_level = 0;
  bit rst_seen = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      n_out    <= -1;
      rst_seen <= 1'b1;
    end else begin
      if ((n_out + 1) % FRAME == 0) m_level <= int'(screen);
      n_out <= n_out + 1;
    end
  end

  logic [12:0] dut_vec;
  assign dut_vec = {LAT, OEN, OCLK, D, C, B, A, r1, g1, b1, r2, g2, b2};

  logic [12:0] prev_vec;
  int cyc = 0, last_lat = -1, rises = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst_seen) begin
      check("model", int'(dut_vec), int'(exp_vec(n_out, m_level)));
      if (n_out >= 0) begin
        check("proto", int'((!OEN && (dut_vec[9:6] != prev_vec[9:6])) || (LAT && !OEN) ||
                            (OCLK && (dut_vec[5:0] != prev_vec[5:0]))), 0);
        if (OCLK && !prev_vec[10]) rises++;
        if (LAT) begin
          if (last_lat >= 0) begin
            check("lat_spacing", cyc - last_lat, ROWP);
            check("oclk_rises", rises, COLS);
          end
          last_lat = cyc;
          rises = 0;
        end
      end else begin
        last_lat = -1;
        rises = 0;
      end
    end
    prev_vec = dut_vec;
  end

  task automatic wait_n(input int target);
    int guard = 0;
    while (n_out < target && guard < 60000) begin
      @(negedge clk);
      guard++;
    end
    if (n_out < target) check("wait_timeout", n_out, target);
  endtask

  task automatic measure_lat(input string name);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!LAT && c < 400);
    check(name, c, 66);
    check({name, "_abcd"}, int'({D, C, B, A}), 0);
  endtask

  task automatic check_rgb(input string name, input logic [2:0] up, input logic [2:0] lo);
    check({name, "_up"}, int'({r1, g1, b1}), int'(up));
    check({name, "_lo"}, int'({r2, g2, b2}), int'(lo));
  endtask

  initial begin
    logic [5:0] edge_vals [4];
    edge_vals[0] = 6'd31; edge_vals[1] = 6'd32; edge_vals[2] = 6'd33; edge_vals[3] = 6'd0;

    reset = 1'b1;
    screen = 6'd0;
    repeat (3) @(negedge clk);
    check("reset_vec", int'(dut_vec), int'(13'b0_1_0_0000_000_000));
    reset = 1'b0;
    measure_lat("first_lat");

    screen = 6'd20;
    wait_n(FRAME + 11*ROWP + 10);
    check_rgb("h20_r11", 3'b000, 3'b010);
    wait_n(FRAME + 12*ROWP + 10);
    check_rgb("h20_r12", 3'b110, 3'b010);

    screen = 6'd63;
    wait_n(2*FRAME + 10);
    check_rgb("h63_r0", 3'b100, 3'b010);
    wait_n(2*FRAME + 8*ROWP + 11);
    check_rgb("h63_r8", 3'b110, 3'b010);

    screen = 6'd10;
    wait_n(3*FRAME + 5*ROWP + 30);
    screen = 6'd40;
    wait_n(3*FRAME + 6*ROWP + 10);
    check_rgb("mid_r6", 3'b000, 3'b010);
    wait_n(4*FRAME + 10);
    check_rgb("next_r0", 3'b100, 3'b010);

    wait_n(4*FRAME + 7*ROWP + 2*COLS + 2 + 100);
    check("pre_reset_oen", int'(OEN), 0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_vec", int'(dut_vec), int'(13'b0_1_0_0000_000_000));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    measure_lat("post_reset_lat");

    for (int k = 0; k < 24; k++) begin
      repeat ($urandom_range(1500, 50)) @(negedge clk);
      screen = (k < 4) ? edge_vals[k] : 6'($urandom_range(63, 0));
    end
    wait_n(n_out + FRAME);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hub75_bar_driver.md
# hub75_bar_driver

Scan driver for the 32×32 HUB75 RGB LED panel, at 1/16 scan, two row halves per address. It consumes the 6-bit `screen` word from the single/multi screen mux and renders it as a vertical level bar across all columns, colour-coded by height. It generates column shift clock, latch, output-enable and row address continuously from the system clock. It sits directly downstream of the screen mux and drives the panel pins.

## Interface
Parameters:
- `COLS`, 32: columns per row, equal to shift-register length.
- `ROW_PAIRS`, 16: scanned address count. Panel height is 2×`ROW_PAIRS`.
- `ON_CYCLES`, 256: `clk` cycles OEN is held low per row.

Ports:
- `clk`  in  1: system clock, single domain.
- `reset`  in  1: synchronous, active-high.
- `screen`  in  6: bar height request, 0–63.
- `r1`, `g1`, `b1`  out  1 each: colour for the upper-half row (y = r).
- `r2`, `g2`, `b2`  out  1 each: colour for the lower-half row (y = r+16).
- `A`, `B`, `C`, `D`  out  1 each: row address, `A` = LSB.
- `LAT`  out  1: latch pulse, active-high.
- `OEN`  out  1: output enable, active-low.
- `OCLK`  out  1: column shift clock. The panel samples on its rising edge.

## Operation
- Reset values, applied on the next edge while `reset` = 1:
  - `OEN` = 1; `LAT` = 0; `OCLK` = 0; all RGB = 0; ABCD = 0.
  - State = SHIFT, row counter r = 0, column counter c = 0.
- Reset asserted at any point abandons the row in progress; there is no partial-row completion.
- FSM states are SHIFT, BLANK, LATCH and SHOW. They loop per row.
- SHIFT lasts 2×`COLS` cycles. For column c:
  - Cycle 2c: RGB is driven for column c, `OCLK` = 0.
  - Cycle 2c+1: RGB is held, `OCLK` = 1.
  - `OEN` = 1 throughout SHIFT.
- BLANK lasts 1 cycle: `OCLK` = 0, `OEN` = 1, RGB = 0.
- LATCH lasts 1 cycle: `LAT` = 1, `OEN` = 1, and ABCD is updated to r.
- SHOW lasts `ON_CYCLES` cycles with `OEN` = 0 and `LAT` = 0. On exit, r increments and wraps from 15 to 0, then the FSM returns to SHIFT.
- Screen capture:
  - `screen` is registered into `level` on the first SHIFT cycle of row r = 0.
  - Changes mid-frame take effect on the next frame only, so there is no tearing.
  - After reset, the capture happens in the first cycle.
- Pixel rule, for any x and physical row y (0 = top):
  - h = min(`level`, 32) and L = 31 − y.
  - Unlit when L ≥ h.
  - Lit colours by L:
    - L 0–15 green (0,1,0).
    - L 16–23 yellow (1,1,0).
    - L 24–31 red (1,0,0).
  - Blue is always 0.
  - Column index does not affect colour.
- Arithmetic: the clamp compares the 6-bit `level` against 32. L is computed as 5-bit 31 − y with no overflow.

## Timing
- Row period is 2×`COLS`+2+`ON_CYCLES`, which is 322 cycles at defaults. The frame is 16 rows, 5152 cycles.
- `LAT` is high for exactly 1 cycle per row.
- ABCD changes only in the LATCH cycle, and always with `OEN` = 1.
- RGB is stable for both the `OCLK` = 0 and `OCLK` = 1 cycles of each column, giving 1 cycle of setup and hold around the rising edge.
- There are exactly `COLS` `OCLK` rising edges between consecutive `LAT` pulses.
- Latency from a `screen` change to display is up to 1 frame, plus the row position, plus one SHOW period.

## Structure
- Package `led_pkg` holds:
  - the `COLS`, `ROW_PAIRS` and `ON_CYCLES` defaults;
  - the `state_t` enum (SHIFT, BLANK, LATCH, SHOW);
  - the `rgb_t` 3-bit typedef with GREEN, YELLOW, RED and OFF constants;
  - the thresholds 16 and 24.
- One sub-module, `bar_pixel`, is purely combinational. It takes (`level`, y[4:0]) and returns `rgb_t`. It is instantiated twice, for y = r and y = r+16.
- Counters, FSM and output registers live in `hub75_bar_driver`. All outputs are registered.

## Test plan
- Reset: assert `reset` for 3 cycles mid-SHOW at r = 7 → next edge `OEN`=1, `LAT`=0, `OCLK`=0, RGB=0, ABCD=0. After release, the first `LAT` appears 66 cycles later with ABCD=0.
- `screen`=0: run 1 frame → every RGB bit is 0. Check 32 `OCLK` rising edges per row, 16 `LAT` pulses, and `LAT` spacing of 322 cycles.
- `screen`=20:
  - Row pair r=12 → upper (1,1,0), lower (0,1,0) on all 32 columns.
  - r=11 → upper (0,0,0), lower (0,1,0).
- `screen`=63 (clamp): r=0 → upper (1,0,0), lower (0,1,0). r=8 → upper (1,1,0). No pixel is ever unlit.
- Mid-frame change: `screen` goes 10→40 during row 5 → rows 5–15 render h=10, e.g. r=6 gives upper (0,0,0) and lower (0,1,0). At next frame, r=0 upper is red.
- Protocol checker over 3 frames:
  - ABCD never changes while `OEN`=0.
  - `LAT` is never high while `OEN`=0.
  - RGB never changes in a cycle where `OCLK`=1.
